// File: rtl/clock_face_renderer.sv
// Double-buffered monochrome clock-face renderer: draws up to NUM_HANDS radial hands
// into a back buffer using an external sin/cos unit and scans the front buffer out to VGA.
module clock_face_renderer #(
    parameter int FB_SIZE   = 64,
    parameter int SCALE     = 7,
    parameter int NUM_HANDS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   slow_clk,
    input  logic [NUM_HANDS*9-1:0] hand_angle,
    input  logic [NUM_HANDS*6-1:0] hand_len,
    input  logic [NUM_HANDS-1:0]   hand_en,
    input  logic [9:0]             horizCounter,
    input  logic [9:0]             vertCounter,
    input  logic [9:0]             x_offset,
    input  logic [9:0]             y_offset,
    output logic                   trig_start,
    output logic [15:0]            trig_angle,
    input  logic                   trig_done,
    input  logic [15:0]            trig_sin,
    input  logic [15:0]            trig_cos,
    output logic                   pixel_bw,
    output logic                   busy,
    output logic                   swap_pulse
);

    localparam int IW = $clog2(FB_SIZE);
    localparam int HW = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1;
    localparam logic [IW-1:0]        LAST_ROW  = IW'(FB_SIZE - 1);
    localparam logic [HW-1:0]        LAST_HAND = HW'(NUM_HANDS - 1);
    localparam logic signed [23:0]   CTR       = 24'(FB_SIZE / 2);
    localparam logic signed [23:0]   FB_LIM    = 24'(FB_SIZE);
    localparam logic [9:0]           FB_W      = 10'(FB_SIZE);
    localparam logic [9:0]           SCALE_W   = 10'(SCALE);

    typedef enum logic [2:0] {IDLE, CLEAR, REQ, WAIT, PLOT, SWAP} state_t;
    state_t state, state_next;

    logic [FB_SIZE-1:0]     fb [2][FB_SIZE];
    logic                   front_sel;
    logic                   back_sel;
    logic                   slow_q, pending, edge_det, start_render;
    logic [NUM_HANDS*9-1:0] ang_snap;
    logic [NUM_HANDS*6-1:0] len_snap;
    logic [NUM_HANDS-1:0]   en_snap;
    logic [HW-1:0]          hand_idx;
    logic [IW-1:0]          row;
    logic [5:0]             r;
    logic [15:0]            sin_q, cos_q;
    logic [8:0]             cur_angle;
    logic [5:0]             cur_len;
    logic                   skip_hand, last_hand, issue, beam_home;

    assign back_sel     = ~front_sel;
    assign edge_det     = slow_clk & ~slow_q;
    assign start_render = edge_det | pending;
    assign cur_angle    = ang_snap[int'(hand_idx)*9 +: 9];
    assign cur_len      = len_snap[int'(hand_idx)*6 +: 6];
    assign skip_hand    = !en_snap[hand_idx] || (cur_len == '0) || (cur_angle >= 9'd360);
    assign last_hand    = (hand_idx == LAST_HAND);
    assign beam_home    = (horizCounter == '0) && (vertCounter == '0);
    assign busy         = (state != IDLE);

    // Hand point at radius r: 24-bit signed products, floor shift back out of Q2.14
    logic signed [23:0] sin_x, cos_x, r_x, prod_x, prod_y, px, py;
    logic               in_fb;
    assign sin_x  = {{8{sin_q[15]}}, sin_q};
    assign cos_x  = {{8{cos_q[15]}}, cos_q};
    assign r_x    = {18'b0, r};
    assign prod_x = sin_x * r_x;
    assign prod_y = cos_x * r_x;
    assign px     = CTR + (prod_x >>> 14);
    assign py     = CTR - (prod_y >>> 14);
    assign in_fb  = !px[23] && (px < FB_LIM) && !py[23] && (py < FB_LIM);

    logic [9:0] h_adj, v_adj, fb_x_full, fb_y_full;
    logic       in_view;
    assign h_adj     = horizCounter - x_offset;
    assign v_adj     = vertCounter - y_offset;
    assign fb_x_full = h_adj / SCALE_W;
    assign fb_y_full = v_adj / SCALE_W;
    assign in_view   = (fb_x_full < FB_W) && (fb_y_full < FB_W);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE:  if (start_render) state_next = CLEAR;
            CLEAR: if (row == LAST_ROW) state_next = REQ;
            REQ: begin
                if (skip_hand) begin
                    if (last_hand) state_next = SWAP;
                end else begin
                    issue      = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT:  if (trig_done) state_next = PLOT;
            PLOT:  if (r == cur_len) state_next = last_hand ? SWAP : REQ;
            SWAP:  if (beam_home) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slow_q     <= 1'b0;
            pending    <= 1'b0;
            front_sel  <= 1'b0;
            trig_start <= 1'b0;
            trig_angle <= '0;
            swap_pulse <= 1'b0;
            pixel_bw   <= 1'b0;
            hand_idx   <= '0;
            row        <= '0;
            r          <= '0;
            sin_q      <= '0;
            cos_q      <= '0;
            ang_snap   <= '0;
            len_snap   <= '0;
            en_snap    <= '0;
            for (int unsigned i = 0; i < FB_SIZE; i++) begin
                fb[0][i] <= '0;
                fb[1][i] <= '0;
            end
        end else begin
            slow_q     <= slow_clk;
            trig_start <= issue;
            swap_pulse <= 1'b0;
            pixel_bw   <= in_view ? fb[front_sel][fb_y_full[IW-1:0]][fb_x_full[IW-1:0]] : 1'b0;
            // Edges seen while rendering collapse into a single follow-up render
            if (state == IDLE)  pending <= 1'b0;
            else if (edge_det)  pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (start_render) begin
                        ang_snap <= hand_angle;
                        len_snap <= hand_len;
                        en_snap  <= hand_en;
                        hand_idx <= '0;
                        row      <= '0;
                    end
                end
                CLEAR: begin
                    fb[back_sel][row] <= '0;
                    row               <= row + 1'b1;
                end
                REQ: begin
                    if (skip_hand) hand_idx   <= hand_idx + 1'b1;
                    else           trig_angle <= {7'b0, cur_angle};
                end
                WAIT: begin
                    if (trig_done) begin
                        sin_q <= trig_sin;
                        cos_q <= trig_cos;
                        r     <= 6'd1;
                    end
                end
                PLOT: begin
                    if (in_fb) fb[back_sel][py[IW-1:0]][px[IW-1:0]] <= 1'b1;
                    if (r == cur_len) hand_idx <= hand_idx + 1'b1;
                    else              r        <= r + 1'b1;
                end
                SWAP: begin
                    if (beam_home) begin
                        front_sel  <= ~front_sel;
                        swap_pulse <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
